// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared state encoding, reset constants and PC helper for the fetch stage
package fetch_stage_pkg;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_HOLD = 2'd2} fetch_state_e;
   localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: variable-latency instruction-memory request/response handshake
interface fetch_stage_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;
   modport master (output req, addr, input ack, rdata);
   modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, instruction-memory requester and IF/ID pipeline register
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEF,
   parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_rst_i,
   input  logic               if_en_i,
   input  logic               id_rst_i,
   input  logic               id_en_i,
   input  logic               redirect_en_i,
   input  logic [31:0]        redirect_pc_i,
   fetch_stage_if.master      imem,
   output logic               if_valid_o,
   output logic               imem_stall_o,
   output logic [31:0]        inst_id_o,
   output logic [31:0]        pc_id_o,
   output logic [31:0]        pc_next_id_o,
   output logic               id_valid_o
);
   fetch_state_e state_q, state_d;
   logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d, buf_q, buf_d;
   logic [31:0] inst_id_q, inst_id_d, pc_id_q, pc_id_d, pc_next_id_q, pc_next_id_d;
   logic        kill_q, kill_d, id_valid_q, id_valid_d;
   logic        avail, redir, go, xfer;
   logic [31:0] tgt, pc_nxt;

   // state and pipeline registers; reset returns to idle with an empty IF/ID
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pc_q         <= PC_RESET;
         req_pc_q     <= PC_RESET;
         buf_q        <= '0;
         kill_q       <= 1'b0;
         inst_id_q    <= NOP_INST;
         pc_id_q      <= '0;
         pc_next_id_q <= '0;
         id_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         buf_q        <= buf_d;
         kill_q       <= kill_d;
         inst_id_q    <= inst_id_d;
         pc_id_q      <= pc_id_d;
         pc_next_id_q <= pc_next_id_d;
         id_valid_q   <= id_valid_d;
      end
   end

   // next state: redirects win, a killed response is dropped, otherwise advance or park in the buffer
   always_comb begin
      redir    = if_rst_i || redirect_en_i;
      tgt      = if_rst_i ? PC_RESET : redirect_pc_i;
      go       = if_en_i && id_en_i;
      pc_nxt   = pc_inc(pc_q);
      xfer     = avail && go && !redir;
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      buf_d    = buf_q;
      kill_d   = kill_q;
      case (state_q)
         S_REQ: begin
            if (redir) begin
               pc_d     = tgt;
               req_pc_d = imem.ack ? tgt : req_pc_q;
               kill_d   = !imem.ack;
            end else if (imem.ack && kill_q) begin
               kill_d   = 1'b0;
               req_pc_d = pc_q;
            end else if (imem.ack && go) begin
               pc_d     = pc_nxt;
               req_pc_d = pc_nxt;
            end else if (imem.ack) begin
               buf_d    = imem.rdata;
               state_d  = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redir || go) begin
               pc_d     = redir ? tgt : pc_nxt;
               req_pc_d = pc_d;
               state_d  = S_REQ;
            end
         end
         default: begin
            pc_d     = redir ? tgt : pc_q;
            req_pc_d = pc_d;
            state_d  = S_REQ;
         end
      endcase
   end

   // output decode: the request address is the registered req_pc so it stays stable until ack
   always_comb begin
      imem.req     = state_q == S_REQ;
      imem.addr    = req_pc_q;
      imem_stall_o = imem.req && !imem.ack;
      avail        = (imem.req && imem.ack && !kill_q) || state_q == S_HOLD;
      if_valid_o   = avail;
   end

   // IF/ID update: flush beats transfer, a disabled register holds, otherwise transfer or bubble
   always_comb begin
      inst_id_d    = id_rst_i ? NOP_INST : !id_en_i ? inst_id_q :
                     xfer ? (state_q == S_HOLD ? buf_q : imem.rdata) : NOP_INST;
      id_valid_d   = !id_rst_i && (id_en_i ? xfer : id_valid_q);
      pc_id_d      = (!id_rst_i && xfer) ? pc_q : pc_id_q;
      pc_next_id_d = (!id_rst_i && xfer) ? pc_nxt : pc_next_id_q;
   end

   assign inst_id_o    = inst_id_q;
   assign pc_id_o      = pc_id_q;
   assign pc_next_id_o = pc_next_id_q;
   assign id_valid_o   = id_valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for the fetch stage with a latency-configurable memory model
module tb_fetch_stage;
   logic        clk = 1'b0, rst = 1'b1;
   logic        if_rst = 1'b0, if_en = 1'b1, id_rst = 1'b0, id_en = 1'b1, redirect_en = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        if_valid, imem_stall, id_valid;
   logic [31:0] inst_id, pc_id, pc_next_id;
   logic        stale_ack = 1'b0;
   int          lat = 0, cnt = 0, n_tests = 0, n_fail = 0;
   logic [31:0] q[$];

   fetch_stage_if bus();

   fetch_stage dut (
      .clk(clk), .rst(rst), .if_rst_i(if_rst), .if_en_i(if_en), .id_rst_i(id_rst), .id_en_i(id_en),
      .redirect_en_i(redirect_en), .redirect_pc_i(redirect_pc), .imem(bus.master),
      .if_valid_o(if_valid), .imem_stall_o(imem_stall), .inst_id_o(inst_id), .pc_id_o(pc_id),
      .pc_next_id_o(pc_next_id), .id_valid_o(id_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, a[31:16] ^ a[15:0] ^ 16'h1234};
   endfunction

   assign bus.ack   = (bus.req && cnt == lat) || stale_ack;
   assign bus.rdata = inst_of(bus.addr);

   always @(posedge clk) cnt <= (bus.req && !bus.ack) ? cnt + 1 : 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      logic upd;
      logic [31:0] e;
      upd = id_en && !id_rst;
      #1;
      if (upd && id_valid && !rst) begin
         if (q.size() == 0) chk("unexpected_id_valid", id_valid, 1'b0);
         else begin
            e = q.pop_front();
            chk("pc_id", pc_id, e);
            chk("inst_id", inst_id, inst_of(e));
            chk("pc_next_id", pc_next_id, e + 32'd4);
         end
      end
   end

   task automatic do_reset(input int l);
      @(negedge clk);
      rst = 1'b1; if_rst = 1'b0; redirect_en = 1'b0; id_rst = 1'b0; if_en = 1'b1; id_en = 1'b1; lat = l;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("drain", q.size(), 0);
      id_en = 1'b0;
   endtask

   task automatic wait_addr(input logic [31:0] a);
      int n = 0;
      while (!(bus.req && bus.addr == a) && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("wait_addr", bus.addr, a);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      chk("rst_req", bus.req, 1'b0);
      chk("rst_stall", imem_stall, 1'b0);
      chk("rst_if_valid", if_valid, 1'b0);
      chk("rst_id_valid", id_valid, 1'b0);
      chk("rst_inst_id", inst_id, 32'h0);
      chk("rst_pc_id", pc_id, 32'h0);
      chk("rst_pc_next_id", pc_next_id, 32'h0);
      chk("rst_addr", bus.addr, 32'h0);
      // zero-latency back-to-back streaming
      for (int i = 0; i < 8; i++) q.push_back(32'(i * 4));
      do_reset(0);
      @(negedge clk);
      chk("p1_req", bus.req, 1'b1);
      chk("p1_addr", bus.addr, 32'h0);
      chk("p1_id_valid0", id_valid, 1'b0);
      chk("p1_if_valid", if_valid, 1'b1);
      @(negedge clk);
      chk("p1_id_valid1", id_valid, 1'b1);
      drain();
      // three-cycle latency with stalls and bubbles
      for (int i = 0; i < 3; i++) q.push_back(32'(i * 4));
      do_reset(2);
      @(negedge clk);
      chk("p2_stall1", imem_stall, 1'b1);
      chk("p2_addr1", bus.addr, 32'h0);
      @(negedge clk);
      chk("p2_stall2", imem_stall, 1'b1);
      chk("p2_addr2", bus.addr, 32'h0);
      chk("p2_id_valid", id_valid, 1'b0);
      @(negedge clk);
      chk("p2_stall_ack", imem_stall, 1'b0);
      chk("p2_if_valid", if_valid, 1'b1);
      @(negedge clk);
      chk("p2_id_valid_on", id_valid, 1'b1);
      chk("p2_addr_next", bus.addr, 32'h4);
      @(negedge clk);
      chk("p2_bubble_valid", id_valid, 1'b0);
      chk("p2_bubble_inst", inst_id, 32'h0);
      drain();
      // ID stall while the response for 0x8 arrives
      for (int i = 0; i < 3; i++) q.push_back(32'(i * 4));
      do_reset(0);
      repeat (3) @(negedge clk);
      id_en = 1'b0;
      @(negedge clk);
      chk("p3_hold_req", bus.req, 1'b0);
      chk("p3_hold_if_valid", if_valid, 1'b1);
      chk("p3_hold_pc_id", pc_id, 32'h4);
      id_en = 1'b1;
      @(negedge clk);
      chk("p3_addr_c", bus.addr, 32'hC);
      chk("p3_req", bus.req, 1'b1);
      chk("p3_sb_empty", q.size(), 0);
      id_en = 1'b0;
      // redirect while the fetch of 0x10 is outstanding
      for (int i = 0; i < 4; i++) q.push_back(32'(i * 4));
      q.push_back(32'h100);
      do_reset(2);
      wait_addr(32'h10);
      chk("p4_stall", imem_stall, 1'b1);
      redirect_en = 1'b1; redirect_pc = 32'h100;
      @(negedge clk);
      redirect_en = 1'b0;
      chk("p4_addr_stable", bus.addr, 32'h10);
      @(negedge clk);
      chk("p4_killed", if_valid, 1'b0);
      @(negedge clk);
      chk("p4_addr_new", bus.addr, 32'h100);
      drain();
      // IF/ID flush while the response for 0x20 is valid
      for (int i = 0; i < 8; i++) q.push_back(32'(i * 4));
      do_reset(0);
      wait_addr(32'h20);
      chk("p5_sb_empty", q.size(), 0);
      id_rst = 1'b1;
      @(negedge clk);
      chk("p5_inst_nop", inst_id, 32'h0);
      chk("p5_id_valid", id_valid, 1'b0);
      chk("p5_addr", bus.addr, 32'h24);
      id_rst = 1'b0;
      q.push_back(32'h24);
      drain();
      // asynchronous reset mid-request, then a stale ack while idle
      do_reset(2);
      @(negedge clk);
      chk("p6_pending", imem_stall, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("p6_req", bus.req, 1'b0);
      chk("p6_stall", imem_stall, 1'b0);
      chk("p6_if_valid", if_valid, 1'b0);
      chk("p6_addr", bus.addr, 32'h0);
      @(negedge clk);
      q.push_back(32'h0); q.push_back(32'h4);
      id_en = 1'b1; rst = 1'b0; stale_ack = 1'b1;
      @(posedge clk);
      #1 stale_ack = 1'b0;
      @(negedge clk);
      chk("p6_first_addr", bus.addr, 32'h0);
      chk("p6_no_stale", id_valid, 1'b0);
      drain();
      // PC wrap-around at the top of the address space
      q.push_back(32'hFFFF_FFFC); q.push_back(32'h0);
      do_reset(0);
      @(negedge clk);
      redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_en = 1'b0;
      chk("p7_addr_top", bus.addr, 32'hFFFF_FFFC);
      chk("p7_bubble", id_valid, 1'b0);
      @(negedge clk);
      chk("p7_addr_wrap", bus.addr, 32'h0);
      chk("p7_pc_next_wrap", pc_next_id, 32'h0);
      drain();
      // if_rst drops a held instruction and refetches from reset PC
      q.push_back(32'h0);
      do_reset(0);
      repeat (2) @(negedge clk);
      id_en = 1'b0;
      @(negedge clk);
      chk("p8_hold_req", bus.req, 1'b0);
      if_rst = 1'b1; id_en = 1'b1;
      @(negedge clk);
      if_rst = 1'b0;
      chk("p8_addr", bus.addr, 32'h0);
      chk("p8_bubble", id_valid, 1'b0);
      q.push_back(32'h0);
      drain();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS 5-stage pipelined CPU. It owns the PC and issues requests on a variable-latency instruction-memory handshake.
- It holds one fetched instruction when ID is stalled and drives the IF/ID pipeline register consumed by the decode/control logic.
- It accepts stage-control signals (if_rst, if_en, id_rst, id_en) and a redirect (jump/branch target) from downstream. It reports if_valid and id_valid back to the pipeline controller.

Parameters:
- PC_RESET, 32'h0000_0000, PC value after reset / if_rst.
- NOP_INST, 32'h0000_0000, instruction word placed in IF/ID on bubble.

Ports:
- clk  in  1  main clock
- rst  in  1  asynchronous active-high reset
- if_rst  in  1  synchronous IF flush; refetch from PC_RESET
- if_en  in  1  IF stage enable
- id_rst  in  1  synchronous IF/ID flush (insert NOP)
- id_en  in  1  IF/ID register enable
- redirect_en  in  1  load new PC (jump/branch taken)
- redirect_pc  in  32  redirect target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (stable while imem_req high)
- imem_ack  in  1  one-cycle response strobe
- imem_rdata  in  32  instruction, valid with imem_ack
- if_valid  out  1  instruction available in IF this cycle
- imem_stall  out  1  request outstanding, no ack this cycle
- inst_id  out  32  IF/ID instruction
- pc_id  out  32  IF/ID instruction address
- pc_next_id  out  32  IF/ID pc+4
- id_valid  out  1  IF/ID contents valid

Behaviour:
- State machine: S_IDLE, S_REQ, S_HOLD.
- Registers: pc, req_pc, buf_inst, kill.
- Reset (async, rst=1):
  - state=S_IDLE; pc=req_pc=PC_RESET; kill=0; buf_inst=0.
  - inst_id=NOP_INST; pc_id=pc_next_id=0; id_valid=0.
  - Combinational outputs at reset: imem_req=0, imem_stall=0, if_valid=0.
- Output decode:
  - imem_req = (state==S_REQ); imem_addr = req_pc.
  - imem_stall = S_REQ && !imem_ack.
  - "avail" = (S_REQ && imem_ack && !kill) || S_HOLD; if_valid = avail.
- S_IDLE → S_REQ unconditionally next cycle; req_pc=pc.
- IF priority, highest first: if_rst, redirect_en, normal.
  - if_rst acts as a redirect to PC_RESET.
  - if_en=0 freezes pc/state, except that an arriving ack is captured into buf_inst (→S_HOLD) so no response is lost.
- Redirect (or if_rst), target T:
  - pc=req_pc=T.
  - In S_REQ without ack: kill=1, stay S_REQ. req_pc updates only after the outstanding ack.
  - In S_REQ with ack: data discarded, kill=0, new request next cycle.
  - In S_HOLD: buffer dropped, →S_REQ.
  - The addressed instruction is never delivered to IF/ID in a redirect cycle.
- S_REQ with ack and kill=1: discard data, kill=0, req_pc=pc, stay S_REQ.
- S_REQ with ack, kill=0, no redirect:
  - If if_en && id_en: transfer to IF/ID; pc=req_pc=pc+4; stay S_REQ (back-to-back, new request same next cycle).
  - Otherwise: buf_inst=rdata; →S_HOLD.
- S_HOLD: imem_req=0. When if_en && id_en: transfer buf_inst; pc=req_pc=pc+4; →S_REQ.
- Transfer loads inst_id = instruction, pc_id = pc, pc_next_id = pc+4, id_valid=1.
- IF/ID update, evaluated each edge:
  - id_rst=1 → NOP_INST, id_valid=0 (overrides transfer; the IF instruction is still consumed and pc advances). id_rst and redirect together → bubble.
  - else id_en=0 → hold.
  - else transfer if avail, otherwise bubble (NOP_INST, id_valid=0).
- Arithmetic: pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- rst asserted mid-request: state returns to S_IDLE. A stale ack arriving while in S_IDLE is ignored.

Decomposition:
- mips_define.vh gets the state encodings FETCH_IDLE/FETCH_REQ/FETCH_HOLD (2-bit) and a NOP instruction constant.
- Single module; no sub-module warranted (one holding register, one FSM).

Test Plan:
- Zero-latency memory (ack same cycle as req), if_en=id_en=1 → pc_id 0,4,8,... on consecutive cycles, id_valid=1 from cycle 2 after reset release.
- 3-cycle memory latency → imem_stall=1 for 2 cycles per fetch, IF/ID shows bubbles (id_valid=0, inst_id=0) between instructions, imem_addr stable while imem_req=1.
- id_en=0 when ack for pc=0x8 arrives → state S_HOLD, imem_req=0; id_en=1 next → inst_id=that word, pc_id=0x8, next request addr 0xC.
- redirect_en with redirect_pc=0x100 while fetch of 0x10 outstanding → 0x10 data discarded on ack, next imem_addr=0x100, first valid pc_id=0x100.
- id_rst=1 while ack valid at pc=0x20 → inst_id=0, id_valid=0; next request addr 0x24.
- Assert rst asynchronously mid-cycle during outstanding request → outputs reset immediately; after release first imem_addr=PC_RESET, no stale instruction reaches IF/ID.
